mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Sits directly upstream of the unified word-addressed memory of the multicycle MIPS core (64 x 32-bit, combinational read, write on posedge clk when we). Accepts one load/store request at a time from the multicycle controller/datapath. Drives word-aligned memory accesses. Implements byte/halfword loads with sign/zero extension, and byte/halfword stores by read-modify-write. Flags misaligned accesses without touching memory.

Parameters:
AW, 32, address width of addr and mem_a
DW, 32, data width (fixed at 32; other values unsupported)

Ports:
clk  in  1  clock, all state updates on posedge
reset_n  in  1  synchronous reset, active-low
req  in  1  request strobe; sampled only in IDLE
we  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
sign_ext  in  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu)
addr  in  AW  byte address
wdata  in  DW  store data, right-justified (byte in [7:0], half in [15:0])
rdata  out  DW  load result, valid while done=1, held until the next done
done  out  1  one-cycle completion pulse
busy  out  1  high in every state except IDLE
err  out  1  valid with done; 1 = misaligned or illegal size
mem_we  out  1  to memory we
mem_a  out  AW  to memory a; always {addr_q[AW-1:2],2'b00}
mem_wd  out  DW  to memory wd
mem_rd  in  DW  from memory rd (combinational)

Behaviour:
- Reset (reset_n low at posedge): state=IDLE; rdata=0; done=0; err=0; busy=0; mem_a=0; mem_wd=0. mem_we is gated combinationally by reset_n, so no write occurs in any cycle with reset_n=0, including mid-RMW.
- Request capture: in IDLE with req=1, register we, size, sign_ext, addr, wdata. req is ignored when busy=1.
- Byte order is big-endian. Byte lane k=addr[1:0] maps to bits [31-8k -: 8]. Half lane addr[1]=0 maps to [31:16]; addr[1]=1 maps to [15:0].
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> ERR state.
- FSM states: IDLE, RD, WR, RMW_WR, ERR, DONE.
  - IDLE -> ERR if the request is misaligned or illegal.
  - IDLE -> RD for any load, or for a sub-word store.
  - IDLE -> WR for a word store.
  - RD: mem_we=0; mem_rd sampled at the end of the cycle. A load registers its extracted/extended result into rdata and goes to DONE. A sub-word store registers the merged word into mem_wd and goes to RMW_WR.
  - WR: mem_wd=wdata_q, mem_we=1 -> DONE.
  - RMW_WR: mem_we=1 with the merged word -> DONE.
  - ERR: no memory access; err registered 1 -> DONE.
  - DONE: done=1 for exactly one cycle; err is 0 unless coming from ERR -> IDLE.
- Merge rule: only the addressed byte/half lane is replaced with wdata_q[7:0]/[15:0]; the other lanes keep the old word.
- Latency, counted from the req-accept edge N: load done at N+2; word store done at N+2; sub-word store done at N+3; error done at N+2.
- Back-to-back requests: a new req is accepted in the IDLE cycle following DONE (minimum 1-cycle gap).
- mem_we is 1 only in WR and RMW_WR, never for loads or errors.

Decomposition:
- Shared package/header mem_access_defs: size codes (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encodings, lane-select helper constants.
- One natural sub-module, mem_lane_mux: combinational extract+extend (load) and merge (store) given word, addr[1:0], size, sign_ext, wdata.
- The FSM stays in mem_access_unit.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x10, then lw @0x10 -> mem_we high exactly 1 cycle; done at N+2; rdata=0xDEADBEEF; err=0.
- Byte loads from word 0x80FF7F01 @0x20: lb @0x20 -> 0xFFFFFF80; lbu @0x20 -> 0x00000080; lb @0x22 -> 0x0000007F; lh @0x22 -> 0x00007F01.
- sb 0xAA @0x21 over word 0x11223344 -> word becomes 0x11AA3344; sh 0xBEEF @0x22 -> 0x11AABEEF; done at N+3; mem_we pulse in cycle N+2 only.
- Misaligned lw @0x06, lh @0x03, and size=11 -> done at N+2 with err=1; mem_we never asserted; memory unchanged.
- Reset mid-RMW: sb issued, reset_n low during the RMW_WR cycle -> no write; memory word unchanged; next cycle busy=0, done=0, rdata=0.
- req held high continuously for 3 loads -> each accepted only in IDLE; done pulses 3 cycles apart; busy deasserted for 1 cycle between requests.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_defs: shared definitions for the memory access unit.
//   - size codes carried on the size port
//   - FSM state encoding
//   - captured request control fields
//   - big-endian lane-enable constants (bit i of a mask covers word bits [8i+7:8i])
//   - misaligned(): the alignment/legality rule used at request accept
package mem_access_defs;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int NUM_LANES = 4;

    // Byte lane 0 (addr[1:0]=0) is the most significant byte; shift right by
    // the byte offset to reach the other lanes.
    localparam logic [NUM_LANES-1:0] BE_BYTE0 = 4'b1000;
    localparam logic [NUM_LANES-1:0] BE_HALF0 = 4'b1100;
    localparam logic [NUM_LANES-1:0] BE_HALF1 = 4'b0011;
    localparam logic [NUM_LANES-1:0] BE_WORD  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_WR,
        ST_ERR,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sign_ext;
    } ctl_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_ILL) ||
               (size == SZ_HALF && a[0]) ||
               (size == SZ_WORD && a != 2'b00);
    endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// mem_lane_mux: combinational lane logic for sub-word accesses (big-endian).
//   word     in  32  word currently read from memory
//   a        in   2  byte offset within the word
//   size     in   2  access size code
//   sign_ext in   1  sign- (1) or zero- (0) extend loaded byte/half
//   wdata    in  32  right-justified store data
//   ld_data  out 32  extracted and extended load result
//   st_data  out 32  word with only the addressed lane(s) replaced
module mem_lane_mux
    import mem_access_defs::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  a,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [NUM_LANES-1:0] be;
    logic [31:0]          rep;

    always_comb begin
        case (a)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        half_sel = a[1] ? word[15:0] : word[31:16];

        case (size)
            SZ_BYTE: ld_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: ld_data = word;
        endcase

        // Replicate store data across all lanes, then let the enables pick
        // which lanes take it.
        be  = BE_WORD;
        rep = wdata;
        case (size)
            SZ_BYTE: begin
                be  = BE_BYTE0 >> a;
                rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be  = a[1] ? BE_HALF1 : BE_HALF0;
                rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign st_data[8*i +: 8] = be[i] ? rep[8*i +: 8] : word[8*i +: 8];
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a 64x32 word-addressed memory.
// One request at a time; byte/half loads are extracted and extended, byte/half
// stores are done as read-modify-write, misaligned/illegal requests complete
// with err=1 and never touch memory.
//   clk, reset_n        clock, synchronous active-low reset
//   req, we, size,      request strobe (sampled in IDLE only) and its
//   sign_ext, addr,     attributes: store/load, size code, extension mode,
//   wdata               byte address, right-justified store data
//   rdata, done, err    load result (held), completion pulse, error flag
//   busy                high in every state except IDLE
//   mem_we, mem_a,      memory write enable, word-aligned address,
//   mem_wd, mem_rd      write data, combinational read data
module mem_access_unit
    import mem_access_defs::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    state_e        state;
    ctl_t          ctl_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] st_data;

    mem_lane_mux u_lane_mux (
        .word     (mem_rd),
        .a        (addr_q[1:0]),
        .size     (ctl_q.size),
        .sign_ext (ctl_q.sign_ext),
        .wdata    (wdata_q),
        .ld_data  (ld_data),
        .st_data  (st_data)
    );

    assign mem_a = {addr_q[AW-1:2], 2'b00};
    assign busy  = (state != ST_IDLE);
    // Gated by reset_n so a reset landing in a write cycle cannot corrupt memory.
    assign mem_we = reset_n && (state == ST_WR || state == ST_RMW_WR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            ctl_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            mem_wd  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: if (req) begin
                    ctl_q   <= '{we: we, size: size, sign_ext: sign_ext};
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    // Word stores write this directly; sub-word stores replace it in RD.
                    mem_wd  <= wdata;
                    if (misaligned(size, addr[1:0]))
                        state <= ST_ERR;
                    else if (we && size == SZ_WORD)
                        state <= ST_WR;
                    else
                        state <= ST_RD;
                end
                ST_RD: begin
                    if (ctl_q.we) begin
                        mem_wd <= st_data;
                        state  <= ST_RMW_WR;
                    end else begin
                        rdata <= ld_data;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_WR, ST_RMW_WR: begin
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_ERR: begin
                    done  <= 1'b1;
                    err   <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
